fake_source: RTL and testbench
==============================

# fake_source

Test-support stream generator that drives a data/valid/ready stream with a programmable arithmetic sequence. It is the transmitting counterpart of `fake_sink` and exercises any stream consumer in benches or on-chip bring-up. It includes a `stall` input for injecting producer-side bubbles, and beat counting and completion outputs for checking.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of `data`, `first_value` and `increment`
- `COUNTER_WIDTH`, 4, width of `count` and `num_sent`

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge
- `reset_n`  in  1  reset, synchronous and active-low
- `start`  in  1  sampled in IDLE; loads the configuration and begins a run
- `first_value`  in  DATA_WIDTH  value of beat 0, captured on `start`
- `increment`  in  DATA_WIDTH  added to the value after each beat, captured on `start`
- `count`  in  COUNTER_WIDTH  number of beats in the run, captured on `start`; 0 means an empty run
- `stall`  in  1  suppresses presentation of a new beat
- `data`  out  DATA_WIDTH  stream payload
- `valid`  out  1  payload valid
- `ready`  in  1  consumer accepts; a handshake occurs when `valid && ready` at the clock edge
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse after the run completes
- `num_sent`  out  COUNTER_WIDTH  handshakes completed in the current or last run

## Operation
- States are IDLE and RUN. Internal registers are `next_value` (DATA_WIDTH) and `remaining` (COUNTER_WIDTH).
- IDLE, `start`=1, `count`≠0:
  - state←RUN, busy←1, num_sent←0, remaining←count.
  - If `stall`=0: valid←1, data←first_value, next_value←first_value+increment.
  - If `stall`=1: valid←0, next_value←first_value.
- IDLE, `start`=1, `count`=0: done←1, num_sent←0, state stays IDLE, busy stays 0.
- RUN, valid=0: if `stall`=0, then valid←1, data←next_value, next_value←next_value+increment. Otherwise hold.
- RUN, valid=1, ready=0: hold `valid` and `data`. `stall` is ignored because a presented beat is never withdrawn.
- RUN, valid=1, ready=1 (handshake): num_sent←num_sent+1, remaining←remaining−1.
  - If remaining was 1: valid←0, busy←0, done←1, state←IDLE.
  - Else if `stall`=0: valid stays 1, data←next_value, next_value advances. This is the back-to-back path at one beat per cycle.
  - Else: valid←0.
- Arithmetic is modulo 2^DATA_WIDTH and wraps silently. `num_sent` cannot overflow because count ≤ 2^COUNTER_WIDTH−1.
- `start` while busy is ignored, and the captured configuration is unchanged.
- `done` is high for exactly one cycle and is otherwise 0.
- `num_sent` holds its final value until the next accepted `start`.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Reset values: data=0, valid=0, busy=0, done=0, num_sent=0, state IDLE.
- Reset mid-run: `valid` is 0 in the cycle after the reset edge, and the run is discarded with no `done` pulse.
- Latency from `start` to first `valid`: the cycle after the `start` cycle, when `stall`=0.
- With `ready` and `stall` held low/high respectively... in steady state with `ready`=1 and `stall`=0, a run of N beats occupies N consecutive cycles. `done` and `busy`=0 appear in the cycle after the last handshake.
- Latency of `stall` to the next beat: the beat appears in the cycle after the first cycle in which `stall`=0.

## Structure
- `fake_source_pkg` holds the state enum typedef (`FS_IDLE`, `FS_RUN`). No other shared constants are needed.
- The block is flat. No sub-module is natural; the datapath is a single adder plus two counters.

## Test plan
All scenarios use DATA_WIDTH=8 and COUNTER_WIDTH=4.
- Reset: hold reset_n=0 for 2 cycles with start=1 -> data=0, valid=0, busy=0, done=0, num_sent=0 throughout.
- Basic run: first=0x12, inc=0x22, count=3, ready=1, stall=0 -> data 0x12, 0x34, 0x56 on 3 consecutive valid cycles, then done=1 for one cycle, busy=0, num_sent=3.
- Backpressure: same run with ready=0 for 2 cycles while 0x34 is presented, and stall=1 during those cycles -> valid stays 1 and data stays 0x34. The beat is accepted when ready=1, and no beat is lost or duplicated.
- Producer stall: stall=1 immediately after the 0x12 handshake, held for 2 cycles -> valid=0 for those cycles, then 0x34 is presented the cycle after stall drops.
- Empty run and wrap: count=0 -> done pulse only, valid never 1. Then first=0xF0, inc=0x20, count=2 -> beats 0xF0, 0x10.
- Abuse: start pulsed mid-run with different configuration -> ignored, and the sequence continues. Reset_n=0 mid-run -> valid=0 next cycle, no done pulse, and the next start runs normally.

Source files
------------

// File: rtl/fake_source_pkg.sv
// Shared types for the fake_source stream generator.
package fake_source_pkg;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_RUN  = 1'b1
    } fs_state_t;

endpackage

// File: rtl/fake_source.sv
// Stream generator emitting a programmable arithmetic sequence on a valid/ready
// interface, with producer-side stall injection and beat/completion reporting.
module fake_source
    import fake_source_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    first_value,
    input  logic [DATA_WIDTH-1:0]    increment,
    input  logic [COUNTER_WIDTH-1:0] count,
    input  logic                     stall,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTER_WIDTH-1:0] num_sent
);

    fs_state_t                state;
    logic [DATA_WIDTH-1:0]    next_value;
    logic [DATA_WIDTH-1:0]    step_value;
    logic [COUNTER_WIDTH-1:0] remaining;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= FS_IDLE;
            data       <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            num_sent   <= '0;
            next_value <= '0;
            step_value <= '0;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                FS_IDLE: begin
                    if (start) begin
                        num_sent <= '0;
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= FS_RUN;
                            busy       <= 1'b1;
                            remaining  <= count;
                            step_value <= increment;
                            if (!stall) begin
                                valid      <= 1'b1;
                                data       <= first_value;
                                next_value <= first_value + increment;
                            end else begin
                                valid      <= 1'b0;
                                next_value <= first_value;
                            end
                        end
                    end
                end
                FS_RUN: begin
                    if (!valid) begin
                        if (!stall) begin
                            valid      <= 1'b1;
                            data       <= next_value;
                            next_value <= next_value + step_value;
                        end
                    end else if (ready) begin
                        num_sent  <= num_sent + COUNTER_WIDTH'(1);
                        remaining <= remaining - COUNTER_WIDTH'(1);
                        if (remaining == COUNTER_WIDTH'(1)) begin
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FS_IDLE;
                        end else if (!stall) begin
                            data       <= next_value;
                            next_value <= next_value + step_value;
                        end else begin
                            valid <= 1'b0;
                        end
                    end
                    // valid && !ready: the presented beat is held regardless of stall
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fake_source.sv
// Directed self-checking bench for fake_source (DATA_WIDTH=8, COUNTER_WIDTH=4).
module tb_fake_source;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] first_value;
    logic [7:0] increment;
    logic [3:0] count;
    logic       stall;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] num_sent;

    int checks;
    int errors;

    fake_source #(
        .DATA_WIDTH   (8),
        .COUNTER_WIDTH(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .first_value(first_value),
        .increment  (increment),
        .count      (count),
        .stall      (stall),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .num_sent   (num_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic v,
                             input logic b, input logic dn, input logic [3:0] n);
        check({tag, ".data"},     32'(data),     32'(d));
        check({tag, ".valid"},    32'(valid),    32'(v));
        check({tag, ".busy"},     32'(busy),     32'(b));
        check({tag, ".done"},     32'(done),     32'(dn));
        check({tag, ".num_sent"}, 32'(num_sent), 32'(n));
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic [3:0] n);
        check({tag, ".valid"},    32'(valid),    32'(1));
        check({tag, ".data"},     32'(data),     32'(d));
        check({tag, ".num_sent"}, 32'(num_sent), 32'(n));
    endtask

    task automatic launch(input logic [7:0] f, input logic [7:0] inc, input logic [3:0] c);
        first_value = f;
        increment   = inc;
        count       = c;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        start       = 1'b1;
        first_value = 8'h55;
        increment   = 8'h01;
        count       = 4'd3;
        stall       = 1'b0;
        ready       = 1'b1;

        // Reset held with start asserted
        step();
        check_all("rst0", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        check_all("rst1", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        step();
        check_all("idle", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);

        // Basic back-to-back run
        launch(8'h12, 8'h22, 4'd3);
        check_all("basic.b0", 8'h12, 1'b1, 1'b1, 1'b0, 4'd0);
        step();
        check_beat("basic.b1", 8'h34, 4'd1);
        step();
        check_beat("basic.b2", 8'h56, 4'd2);
        step();
        check_all("basic.done", 8'h56, 1'b0, 1'b0, 1'b1, 4'd3);
        step();
        check("basic.done_clr", 32'(done), 32'(0));
        check("basic.hold_n", 32'(num_sent), 32'(3));

        // Consumer backpressure with stall asserted during the hold
        launch(8'h12, 8'h22, 4'd3);
        check_beat("bp.b0", 8'h12, 4'd0);
        step();
        check_beat("bp.b1", 8'h34, 4'd1);
        ready = 1'b0;
        stall = 1'b1;
        step();
        check_beat("bp.hold0", 8'h34, 4'd1);
        step();
        check_beat("bp.hold1", 8'h34, 4'd1);
        ready = 1'b1;
        stall = 1'b0;
        step();
        check_beat("bp.b2", 8'h56, 4'd2);
        step();
        check_all("bp.done", 8'h56, 1'b0, 1'b0, 1'b1, 4'd3);

        // Producer stall right after the first handshake
        launch(8'h12, 8'h22, 4'd3);
        check_beat("st.b0", 8'h12, 4'd0);
        stall = 1'b1;
        step();
        check("st.gap0.valid", 32'(valid), 32'(0));
        check("st.gap0.n", 32'(num_sent), 32'(1));
        check("st.gap0.busy", 32'(busy), 32'(1));
        step();
        check("st.gap1.valid", 32'(valid), 32'(0));
        stall = 1'b0;
        step();
        check_beat("st.b1", 8'h34, 4'd1);
        step();
        check_beat("st.b2", 8'h56, 4'd2);
        step();
        check_all("st.done", 8'h56, 1'b0, 1'b0, 1'b1, 4'd3);
        step();

        // Empty run
        launch(8'hAA, 8'h01, 4'd0);
        check("empty.done", 32'(done), 32'(1));
        check("empty.valid", 32'(valid), 32'(0));
        check("empty.busy", 32'(busy), 32'(0));
        check("empty.n", 32'(num_sent), 32'(0));
        step();
        check("empty.done_clr", 32'(done), 32'(0));
        check("empty.valid2", 32'(valid), 32'(0));

        // Wrapping arithmetic
        launch(8'hF0, 8'h20, 4'd2);
        check_beat("wrap.b0", 8'hF0, 4'd0);
        step();
        check_beat("wrap.b1", 8'h10, 4'd1);
        step();
        check_all("wrap.done", 8'h10, 1'b0, 1'b0, 1'b1, 4'd2);
        step();

        // Start while busy is ignored
        launch(8'h12, 8'h22, 4'd3);
        check_beat("ab.b0", 8'h12, 4'd0);
        first_value = 8'h99;
        increment   = 8'h01;
        count       = 4'd5;
        start       = 1'b1;
        step();
        check_beat("ab.b1", 8'h34, 4'd1);
        start = 1'b0;
        step();
        check_beat("ab.b2", 8'h56, 4'd2);
        step();
        check_all("ab.done", 8'h56, 1'b0, 1'b0, 1'b1, 4'd3);
        step();

        // Reset mid-run discards the run without a done pulse
        launch(8'h12, 8'h22, 4'd3);
        check_beat("mr.b0", 8'h12, 4'd0);
        reset_n = 1'b0;
        step();
        check_all("mr.rst", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b1;
        step();
        check("mr.nodone", 32'(done), 32'(0));
        check("mr.novalid", 32'(valid), 32'(0));
        launch(8'hF0, 8'h20, 4'd2);
        check_beat("mr.r0", 8'hF0, 4'd0);
        step();
        check_beat("mr.r1", 8'h10, 4'd1);
        step();
        check_all("mr.done", 8'h10, 1'b0, 1'b0, 1'b1, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
